// File: rtl/sha256_wb_arbiter.sv
// Two-master Wishbone arbiter in front of the single SHA256 slave. It grants round-robin,
// supports multi-transaction locking, and releases an abandoned lock through an idle watchdog.
module sha256_wb_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [2*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [2*DATA_WIDTH-1:0] m_dat_i,
  input  logic [7:0]              m_sel_i,
  input  logic [1:0]              m_we_i,
  input  logic [1:0]              m_cyc_i,
  input  logic [1:0]              m_stb_i,
  input  logic [1:0]              m_lock_i,
  output logic [2*DATA_WIDTH-1:0] m_dat_o,
  output logic [1:0]              m_ack_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  output logic [3:0]              s_sel_o,
  output logic                    s_we_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  input  logic                    s_ack_i,
  output logic [1:0]              grant_o,
  output logic                    timeout_o
);

  localparam int CNT_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam bit WDOG_EN = (IDLE_TIMEOUT > 0);

  typedef enum logic {ST_IDLE = 1'b0, ST_OWNED = 1'b1} state_t;

  state_t           state_r, state_s;
  logic             owner_r, owner_s;
  logic             rr_last_r, rr_last_s;
  logic [CNT_W-1:0] idle_cnt_r, idle_cnt_s;
  logic [1:0]       grant_s;
  logic             timeout_s;
  logic             own_cyc_s, own_lock_s;

  assign own_cyc_s  = m_cyc_i[owner_r];
  assign own_lock_s = m_lock_i[owner_r];

  // Next-state logic: arbitration in IDLE, then release/watchdog decisions in OWNED.
  always_comb begin
    state_s    = state_r;
    owner_s    = owner_r;
    rr_last_s  = rr_last_r;
    idle_cnt_s = {CNT_W{1'b0}};
    grant_s    = grant_o;
    timeout_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (|m_cyc_i) begin
          state_s   = ST_OWNED;
          // On a tie the master that did not win last time gets the core.
          if (&m_cyc_i) begin
            owner_s = ~rr_last_r;
          end else begin
            owner_s = m_cyc_i[1];
          end
          rr_last_s = owner_s;
          grant_s   = owner_s ? 2'b10 : 2'b01;
        end else begin
          grant_s = 2'b00;
        end
      end
      ST_OWNED: begin
        if (own_cyc_s) begin
          idle_cnt_s = {CNT_W{1'b0}};
        end else if (!own_lock_s) begin
          state_s = ST_IDLE;
          grant_s = 2'b00;
        end else if (WDOG_EN && (idle_cnt_r == CNT_LAST)) begin
          state_s   = ST_IDLE;
          grant_s   = 2'b00;
          timeout_s = 1'b1;
        end else if (idle_cnt_r != CNT_MAX) begin
          idle_cnt_s = idle_cnt_r + CNT_W'(1);
        end else begin
          idle_cnt_s = idle_cnt_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        grant_s = 2'b00;
      end
    endcase
  end

  // State, owner, round-robin pointer, watchdog counter and registered status outputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r    <= ST_IDLE;
      owner_r    <= 1'b0;
      rr_last_r  <= 1'b1;
      idle_cnt_r <= {CNT_W{1'b0}};
      grant_o    <= 2'b00;
      timeout_o  <= 1'b0;
    end else begin
      state_r    <= state_s;
      owner_r    <= owner_s;
      rr_last_r  <= rr_last_s;
      idle_cnt_r <= idle_cnt_s;
      grant_o    <= grant_s;
      timeout_o  <= timeout_s;
    end
  end

  // Bus muxes on the registered grant; an async reset clears grant and so aborts s_cyc_o at once.
  always_comb begin
    s_adr_o = {ADDR_WIDTH{1'b0}};
    s_dat_o = {DATA_WIDTH{1'b0}};
    s_sel_o = 4'h0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    m_dat_o = {(2*DATA_WIDTH){1'b0}};
    m_ack_o = 2'b00;
    case (grant_o)
      2'b01: begin
        s_adr_o                  = m_adr_i[ADDR_WIDTH-1:0];
        s_dat_o                  = m_dat_i[DATA_WIDTH-1:0];
        s_sel_o                  = m_sel_i[3:0];
        s_we_o                   = m_we_i[0];
        s_cyc_o                  = m_cyc_i[0];
        s_stb_o                  = m_stb_i[0];
        m_dat_o[DATA_WIDTH-1:0]  = s_dat_i;
        m_ack_o[0]               = s_ack_i;
      end
      2'b10: begin
        s_adr_o                           = m_adr_i[2*ADDR_WIDTH-1:ADDR_WIDTH];
        s_dat_o                           = m_dat_i[2*DATA_WIDTH-1:DATA_WIDTH];
        s_sel_o                           = m_sel_i[7:4];
        s_we_o                            = m_we_i[1];
        s_cyc_o                           = m_cyc_i[1];
        s_stb_o                           = m_stb_i[1];
        m_dat_o[2*DATA_WIDTH-1:DATA_WIDTH] = s_dat_i;
        m_ack_o[1]                        = s_ack_i;
      end
      default: begin
        s_cyc_o = 1'b0;
      end
    endcase
  end

endmodule
